// File: rtl/fuzz_ctrl_pkg.sv
// ============================================================================
//  fuzz_ctrl_pkg
//  Shared state/status encodings and a saturating-increment helper for the
//  fuzzing round controller.
//  Revision: 1.0
// ============================================================================
`default_nettype none

package fuzz_ctrl_pkg;

    localparam int unsigned SAT_MAX_W = 64;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        RESET = 3'd2,
        RUN   = 3'd3,
        DONE  = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        PASS        = 2'd0,
        TIMEOUT     = 2'd1,
        STALL_ABORT = 2'd2
    } status_e;

    // Increment that sticks at the all-ones value of a width-bit counter.
    function automatic logic [SAT_MAX_W-1:0] sat_inc(input logic [SAT_MAX_W-1:0] value,
                                                     input int unsigned         width);
        logic [SAT_MAX_W-1:0] max_val;
        max_val = (width >= SAT_MAX_W) ? '1 : ((64'd1 << width) - 64'd1);
        return (value >= max_val) ? max_val : value + 64'd1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/fuzz_stall_detector.sv
// ============================================================================
//  fuzz_stall_detector
//  Counts cycles without coverage progress and flags when the count reaches
//  a coverage-scaled threshold.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module fuzz_stall_detector #(
    parameter int unsigned COV_W       = 30,
    parameter int unsigned CNT_W       = 32,
    parameter int unsigned STALL_BASE  = 1000,
    parameter int unsigned STALL_SHIFT = 19
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             run,
    input  logic [COV_W-1:0] cov,
    output logic             irq_raw
);
    import fuzz_ctrl_pkg::*;

    logic [COV_W-1:0] pre_cov_q, pre_cov_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] thresh;

    // Higher coverage earns a proportionally longer patience window.
    assign thresh = CNT_W'(STALL_BASE) * (CNT_W'(cov >> STALL_SHIFT) + CNT_W'(1));

    always_comb begin
        pre_cov_d   = pre_cov_q;
        stall_cnt_d = stall_cnt_q;
        if (clear) begin
            pre_cov_d   = cov;
            stall_cnt_d = '0;
        end else if (run) begin
            if (cov != pre_cov_q) begin
                pre_cov_d   = cov;
                stall_cnt_d = '0;
            end else begin
                stall_cnt_d = CNT_W'(sat_inc(64'(stall_cnt_q), CNT_W));
            end
        end
    end

    assign irq_raw = run && !clear && (stall_cnt_d >= thresh);

    always_ff @(posedge clock) begin
        if (!reset) begin
            pre_cov_q   <= '0;
            stall_cnt_q <= '0;
        end else begin
            pre_cov_q   <= pre_cov_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/fuzz_round_ctrl.sv
// ============================================================================
//  fuzz_round_ctrl
//  Sequences one fuzzing round: load, DUT reset, run with stall/watchdog
//  interrupt, and reports pass/timeout/stall-abort with the RUN cycle count.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module fuzz_round_ctrl #(
    parameter int unsigned COV_W        = 30,
    parameter int unsigned CNT_W        = 32,
    parameter int unsigned RESET_CYCLES = 8,
    parameter int unsigned STALL_BASE   = 1000,
    parameter int unsigned STALL_SHIFT  = 19,
    parameter int unsigned WATCHDOG     = 50000,
    parameter int unsigned IRQ_ABORT    = 4096,
    parameter int unsigned MAX_CYCLES   = 20000000
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    output logic             load_req,
    input  logic             load_ack,
    output logic             dut_reset,
    input  logic [COV_W-1:0] cov,
    input  logic [63:0]      tohost,
    output logic             irq,
    output logic             busy,
    output logic             done,
    output logic [1:0]       status,
    output logic [CNT_W-1:0] cycles
);
    import fuzz_ctrl_pkg::*;

    state_e           state_q, state_d;
    status_e          status_q, status_d;
    logic [CNT_W-1:0] run_cnt_q, run_cnt_d;
    logic [CNT_W-1:0] irq_cnt_q, irq_cnt_d;
    logic [CNT_W-1:0] rst_cnt_q, rst_cnt_d;
    logic [CNT_W-1:0] cycles_q, cycles_d;
    logic             irq_q, irq_d;
    logic             stall_clear;
    logic             stall_run;
    logic             irq_raw;
    logic             unused_tohost_bits;

    assign unused_tohost_bits = ^tohost[63:1];

    fuzz_stall_detector #(
        .COV_W       (COV_W),
        .CNT_W       (CNT_W),
        .STALL_BASE  (STALL_BASE),
        .STALL_SHIFT (STALL_SHIFT)
    ) u_stall (
        .clock   (clock),
        .reset   (reset),
        .clear   (stall_clear),
        .run     (stall_run),
        .cov     (cov),
        .irq_raw (irq_raw)
    );

    always_comb begin
        state_d     = state_q;
        status_d    = status_q;
        run_cnt_d   = run_cnt_q;
        irq_cnt_d   = irq_cnt_q;
        rst_cnt_d   = rst_cnt_q;
        cycles_d    = cycles_q;
        irq_d       = 1'b0;
        stall_clear = 1'b0;
        stall_run   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) state_d = LOAD;
            end
            LOAD: begin
                rst_cnt_d = '0;
                if (load_ack) state_d = RESET;
            end
            RESET: begin
                stall_clear = 1'b1;
                run_cnt_d   = '0;
                irq_cnt_d   = '0;
                rst_cnt_d   = CNT_W'(sat_inc(64'(rst_cnt_q), CNT_W));
                if (rst_cnt_q >= CNT_W'(RESET_CYCLES - 1)) state_d = RUN;
            end
            RUN: begin
                stall_run = 1'b1;
                run_cnt_d = CNT_W'(sat_inc(64'(run_cnt_q), CNT_W));
                irq_cnt_d = irq_q ? CNT_W'(sat_inc(64'(irq_cnt_q), CNT_W)) : '0;
                // Exit checks use this cycle's updated counts so cycles == RUN cycles spent.
                if (tohost[0]) begin
                    state_d  = DONE;
                    status_d = PASS;
                end else if (run_cnt_d >= CNT_W'(MAX_CYCLES)) begin
                    state_d  = DONE;
                    status_d = TIMEOUT;
                end else if (irq_cnt_d >= CNT_W'(IRQ_ABORT)) begin
                    state_d  = DONE;
                    status_d = STALL_ABORT;
                end
                if (state_d == DONE) begin
                    cycles_d = run_cnt_d;
                end else begin
                    irq_d = irq_raw || (run_cnt_d >= CNT_W'(WATCHDOG));
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q   <= IDLE;
            status_q  <= PASS;
            run_cnt_q <= '0;
            irq_cnt_q <= '0;
            rst_cnt_q <= '0;
            cycles_q  <= '0;
            irq_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            status_q  <= status_d;
            run_cnt_q <= run_cnt_d;
            irq_cnt_q <= irq_cnt_d;
            rst_cnt_q <= rst_cnt_d;
            cycles_q  <= cycles_d;
            irq_q     <= irq_d;
        end
    end

    assign load_req  = (state_q == LOAD);
    assign dut_reset = (state_q != RUN);
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign irq       = irq_q;
    assign status    = status_q;
    assign cycles    = cycles_q;

endmodule

`default_nettype wire

// File: tb/tb_fuzz_round_ctrl.sv
// ============================================================================
//  tb_fuzz_round_ctrl
//  Round-level checker for fuzz_round_ctrl with table, directed and random rounds.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module tb_fuzz_round_ctrl;

    localparam int unsigned COV_W        = 16;
    localparam int unsigned CNT_W        = 32;
    localparam int unsigned RESET_CYCLES = 3;
    localparam int unsigned STALL_BASE   = 40;
    localparam int unsigned STALL_SHIFT  = 4;
    localparam int unsigned WATCHDOG     = 300;
    localparam int unsigned IRQ_ABORT    = 8;
    localparam int unsigned MAX_CYCLES   = 305;

    logic             clock = 1'b0;
    logic             reset;
    logic             start;
    logic             load_ack;
    logic [COV_W-1:0] cov;
    logic [63:0]      tohost;
    logic             load_req;
    logic             dut_reset;
    logic             irq;
    logic             busy;
    logic             done;
    logic [1:0]       status;
    logic [CNT_W-1:0] cycles;

    int n_vec  = 0;
    int n_miss = 0;

    fuzz_round_ctrl #(
        .COV_W        (COV_W),
        .CNT_W        (CNT_W),
        .RESET_CYCLES (RESET_CYCLES),
        .STALL_BASE   (STALL_BASE),
        .STALL_SHIFT  (STALL_SHIFT),
        .WATCHDOG     (WATCHDOG),
        .IRQ_ABORT    (IRQ_ABORT),
        .MAX_CYCLES   (MAX_CYCLES)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .load_req  (load_req),
        .load_ack  (load_ack),
        .dut_reset (dut_reset),
        .cov       (cov),
        .tohost    (tohost),
        .irq       (irq),
        .busy      (busy),
        .done      (done),
        .status    (status),
        .cycles    (cycles)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    function automatic longint thresh_of(input longint c);
        return (longint'(STALL_BASE) * ((c >> STALL_SHIFT) + 1)) & 64'hFFFF_FFFF;
    endfunction

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    // Drives one full round from an IDLE cycle and predicts every output from
    // the round's rules: stall = cycles since coverage last moved.
    task automatic run_round(input int ack_delay, input int mode, input int cov_base,
                             input int change_at, input int tohost_at, input bit hold,
                             input int abort_at, output int got_status,
                             output int got_cycles, output bit aborted);
        logic [COV_W-1:0] cur_cov;
        logic [COV_W-1:0] ref_cov;
        int  last_change;
        int  irq_run;
        int  exp_status;
        int  k;
        bit  exp_irq;
        bit  exiting;
        got_status = -1;
        got_cycles = -1;
        aborted    = 1'b0;
        exp_status = 0;

        check("idle_busy", busy, 0);
        check("idle_dut_reset", dut_reset, 1);
        check("idle_load_req", load_req, 0);
        check("idle_irq", irq, 0);
        start    = 1'b1;
        load_ack = rbit();
        tohost   = {$urandom, $urandom};
        tick();

        for (int j = 0; j <= ack_delay; j++) begin
            check("load_req_high", load_req, 1);
            check("load_dut_reset", dut_reset, 1);
            check("load_busy", busy, 1);
            start    = hold ? 1'b1 : rbit();
            load_ack = (j == ack_delay);
            tick();
        end

        cur_cov = (mode == 3) ? COV_W'($urandom_range(0, 255)) : COV_W'(cov_base);
        for (int r = 0; r < int'(RESET_CYCLES); r++) begin
            check("reset_dut_reset", dut_reset, 1);
            check("reset_load_req", load_req, 0);
            check("reset_irq", irq, 0);
            check("reset_busy", busy, 1);
            cov      = cur_cov;
            tohost   = {$urandom, $urandom};
            load_ack = rbit();
            start    = hold ? 1'b1 : rbit();
            tick();
        end

        ref_cov     = cur_cov;
        last_change = 0;
        irq_run     = 0;
        exp_irq     = 1'b0;
        exiting     = 1'b0;
        k           = 0;
        while (!exiting) begin
            k++;
            check("run_dut_reset", dut_reset, 0);
            check("run_irq", irq, exp_irq);
            check("run_done", done, 0);
            check("run_busy", busy, 1);
            check("run_load_req", load_req, 0);
            if (k == abort_at) begin
                reset = 1'b0;
                tick();
                reset = 1'b1;
                start = 1'b0;
                check("abort_busy", busy, 0);
                check("abort_dut_reset", dut_reset, 1);
                check("abort_irq", irq, 0);
                check("abort_done", done, 0);
                check("abort_status", status, 0);
                check("abort_cycles", cycles, 0);
                tick();
                check("abort_idle_done", done, 0);
                check("abort_idle_busy", busy, 0);
                aborted = 1'b1;
                return;
            end
            case (mode)
                0:       cur_cov = COV_W'(cov_base);
                1:       cur_cov = COV_W'(cov_base ^ (k & 1));
                2:       cur_cov = (k < change_at) ? COV_W'(cov_base) : COV_W'(cov_base + 1);
                default: if ($urandom_range(0, 39) == 0) cur_cov = COV_W'($urandom_range(0, 255));
            endcase
            cov      = cur_cov;
            tohost   = ({$urandom, $urandom} & ~64'd1) | 64'(k == tohost_at);
            load_ack = rbit();
            start    = hold ? 1'b1 : rbit();

            if (cur_cov != ref_cov) begin
                ref_cov     = cur_cov;
                last_change = k;
            end
            irq_run = exp_irq ? irq_run + 1 : 0;
            if (k == tohost_at) begin
                exiting = 1'b1; exp_status = 0;
            end else if (k >= int'(MAX_CYCLES)) begin
                exiting = 1'b1; exp_status = 1;
            end else if (irq_run >= int'(IRQ_ABORT)) begin
                exiting = 1'b1; exp_status = 2;
            end
            exp_irq = (longint'(k - last_change) >= thresh_of(longint'(ref_cov))) ||
                      (k >= int'(WATCHDOG));
            tick();
        end

        check("done_pulse", done, 1);
        check("done_status", status, exp_status);
        check("done_cycles", cycles, k);
        check("done_irq", irq, 0);
        check("done_dut_reset", dut_reset, 1);
        got_status = int'(status);
        got_cycles = int'(cycles);
        start  = hold ? 1'b1 : rbit();
        tohost = {$urandom, $urandom};
        tick();
        check("post_done_low", done, 0);
        check("post_busy", busy, 0);
        check("post_status_held", status, exp_status);
        check("post_cycles_held", cycles, k);
        start    = hold;
        load_ack = 1'b0;
        tohost   = '0;
    endtask

    typedef struct {
        int ack_delay;
        int mode;
        int cov_base;
        int change_at;
        int tohost_at;
        bit hold;
        int exp_status;
        int exp_cycles;
    } vec_t;

    vec_t vecs[10];

    initial begin
        int gs, gc;
        bit ab;
        bit pending_start;

        vecs[0] = '{4, 1, 0,      0,  100, 1'b0, 0, 100};
        vecs[1] = '{0, 0, 5,      0,  0,   1'b0, 2, 48};
        vecs[2] = '{2, 0, 32,     0,  0,   1'b0, 2, 128};
        vecs[3] = '{1, 1, 0,      0,  0,   1'b0, 1, 305};
        vecs[4] = '{3, 1, 0,      0,  305, 1'b0, 0, 305};
        vecs[5] = '{0, 2, 5,      45, 0,   1'b0, 2, 93};
        vecs[6] = '{1, 0, 5,      0,  48,  1'b0, 0, 48};
        vecs[7] = '{0, 0, 5,      0,  1,   1'b1, 0, 1};
        vecs[8] = '{2, 0, 'h3F0,  0,  0,   1'b1, 1, 305};
        vecs[9] = '{5, 1, 0,      0,  60,  1'b0, 0, 60};

        reset    = 1'b0;
        start    = 1'b1;
        load_ack = 1'b1;
        cov      = '0;
        tohost   = 64'd1;
        tick();
        tick();
        check("rst_busy", busy, 0);
        check("rst_dut_reset", dut_reset, 1);
        check("rst_load_req", load_req, 0);
        check("rst_irq", irq, 0);
        check("rst_done", done, 0);
        check("rst_status", status, 0);
        check("rst_cycles", cycles, 0);

        reset = 1'b1;
        start = 1'b0;
        tick();
        check("idle_ack_ignored", load_req, 0);
        check("idle_stays", busy, 0);
        load_ack = 1'b0;
        tohost   = '0;
        tick();

        for (int i = 0; i < 10; i++) begin
            run_round(vecs[i].ack_delay, vecs[i].mode, vecs[i].cov_base, vecs[i].change_at,
                      vecs[i].tohost_at, vecs[i].hold, 0, gs, gc, ab);
            check($sformatf("tbl%0d_status", i), gs, vecs[i].exp_status);
            check($sformatf("tbl%0d_cycles", i), gc, vecs[i].exp_cycles);
        end

        // Reset while irq is active, then a clean round must start from zeroed counters.
        run_round(0, 0, 5, 0, 0, 1'b0, 45, gs, gc, ab);
        check("midrun_reset_taken", ab, 1);
        run_round(0, 0, 5, 0, 0, 1'b0, 0, gs, gc, ab);
        check("after_reset_status", gs, 2);
        check("after_reset_cycles", gc, 48);

        pending_start = 1'b0;
        for (int n = 0; n < 20; n++) begin
            int  ad, md, cb, ca, ta, aa;
            bit  hd;
            if (!pending_start) begin
                for (int g = 0; g < int'($urandom_range(0, 3)); g++) begin
                    load_ack = rbit();
                    tohost   = {$urandom, $urandom};
                    tick();
                    check("gap_busy", busy, 0);
                    check("gap_done", done, 0);
                end
                load_ack = 1'b0;
            end
            ad = $urandom_range(0, 6);
            md = $urandom_range(0, 3);
            cb = $urandom_range(0, 255);
            ca = $urandom_range(1, 200);
            ta = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 320));
            hd = ($urandom_range(0, 3) == 0);
            aa = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 50)) : 0;
            run_round(ad, md, cb, ca, ta, hd, aa, gs, gc, ab);
            pending_start = hd && !ab;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

`default_nettype wire
